serial_word_assembler: RTL and testbench

Consumes the registered serial bit stream from the d_ff capture stage and assembles it into WIDTH-bit parallel words. Words are presented downstream on a valid/ready handshake through a one-word output holding register, so the shifter keeps accepting bits while a finished word waits. Framing is marked by a start strobe. Overruns and mid-frame restarts are flagged rather than stalling the serial side, because the serial side cannot be back-pressured.

---
 rtl/serial_word_assembler.sv | 169 ++++++++++++++++
 tb/tb_serial_word_assembler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with a one-word valid/ready output holding register.
// Optional even-parity checking is compiled in with the SERIAL_PARITY_CHECK_EN macro.
module serial_word_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  // Handshake: a word moves downstream on any edge where dout_valid & dout_ready;
  // dout and parity_err are held unchanged while dout_valid=1 and dout_ready=0.

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             last_data;
  logic             can_load;
`ifdef SERIAL_PARITY_CHECK_EN
  logic             word_perr;
  logic             perr_q;
`endif

  always_comb begin
    if (MSB_FIRST) begin
      shifted   = {sreg[WIDTH-2:0], din};
      first_bit = WIDTH'(din);
    end else begin
      shifted   = {din, sreg[WIDTH-1:1]};
      first_bit = {din, {(WIDTH-1){1'b0}}};
    end
  end

  assign last_data = (bit_cnt == CW'(WIDTH - 1));
  assign can_load  = !dout_valid || dout_ready;

  // A word completes on the last bit of the frame: the final data bit, or the parity bit.
  always_comb begin
    complete = 1'b0;
    word     = shifted;
`ifdef SERIAL_PARITY_CHECK_EN
    word_perr = 1'b0;
    if (din_valid && !start && state == PAR) begin
      complete  = 1'b1;
      word      = sreg;
      word_perr = (^sreg) ^ din;
    end
`else
    if (din_valid && !start && state == SHIFT && last_data) begin
      complete = 1'b1;
      word     = shifted;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;

      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      if (complete) begin
        if (can_load) begin
          dout       <= word;
          dout_valid <= 1'b1;
`ifdef SERIAL_PARITY_CHECK_EN
          perr_q     <= word_perr;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (din_valid && start) begin
            sreg    <= first_bit;
            bit_cnt <= CW'(1);
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (din_valid) begin
            if (start) begin
              frame_err <= 1'b1;
              sreg      <= first_bit;
              bit_cnt   <= CW'(1);
            end else if (last_data) begin
              sreg <= shifted;
`ifdef SERIAL_PARITY_CHECK_EN
              bit_cnt <= bit_cnt + CW'(1);
              state   <= PAR;
`else
              bit_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
`endif
            end else begin
              sreg    <= shifted;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
`ifdef SERIAL_PARITY_CHECK_EN
        PAR: begin
          if (din_valid) begin
            if (start) begin
              frame_err <= 1'b1;
              sreg      <= first_bit;
              bit_cnt   <= CW'(1);
              state     <= SHIFT;
            end else begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_PARITY_CHECK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler: an MSB-first and an LSB-first instance share stimulus.
// Parity checks are compiled when SERIAL_PARITY_CHECK_EN is defined.
module tb_serial_word_assembler;

`ifdef SERIAL_PARITY_CHECK_EN
  localparam bit par_en = 1'b1;
`else
  localparam bit par_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       start = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, busy_m, busy_l, ferr_m, ferr_l, ovr_m, ovr_l, perr_m, perr_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready), .busy(busy_m),
    .frame_err(ferr_m), .overrun(ovr_m), .parity_err(perr_m)
  );

  serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready), .busy(busy_l),
    .frame_err(ferr_l), .overrun(ovr_l), .parity_err(perr_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    din       = b;
    start     = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    start     = 1'b0;
  endtask

  // Sends w MSB first (start on the first bit), then the parity bit p when parity is built in.
  // ready_last raises dout_ready just before the edge that completes the word.
  task automatic send_word(input logic [7:0] w, input logic p, input logic ready_last);
    for (int i = 7; i >= 0; i--) begin
      if (ready_last && i == 0 && !par_en) dout_ready = 1'b1;
      send_bit(w[i], i == 7);
    end
    if (par_en) begin
      if (ready_last) dout_ready = 1'b1;
      send_bit(p, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    start     = 1'b0;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    dout_ready = 1'b0;
    rst = 1'b1;
    idle();
    idle();
    check("rst_dout", dout_m, 8'h00);
    check("rst_valid", valid_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    check("rst_frame_err", ferr_m, 1'b0);
    check("rst_overrun", ovr_m, 1'b0);
    check("rst_parity_err", perr_m, 1'b0);
    check("rst_valid_lsb", valid_l, 1'b0);
    rst = 1'b0;
    idle();

    // Basic word 8'hA5, ready high
    dout_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    check("t1_busy_after_start", busy_m, 1'b1);
    send_word_tail();
    check("t1_dout", dout_m, 8'hA5);
    check("t1_valid", valid_m, 1'b1);
    check("t1_busy_done", busy_m, 1'b0);
    check("t1_dout_lsb", dout_l, 8'hA5);
    idle();
    check("t1_valid_drop", valid_m, 1'b0);

    // Bit order: 1 then seven 0s
    send_word(8'h80, 1'b1, 1'b0);
    check("t2_dout_msb", dout_m, 8'h80);
    check("t2_dout_lsb", dout_l, 8'h01);
    check("t2_valid_lsb", valid_l, 1'b1);
    idle();

    // Backpressure and overrun; the two words are back-to-back
    dout_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b0);
    check("t3_first_dout", dout_m, 8'h11);
    check("t3_no_overrun_yet", ovr_m, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    check("t3_dout_held", dout_m, 8'h11);
    check("t3_valid_held", valid_m, 1'b1);
    check("t3_overrun", ovr_m, 1'b1);
    dout_ready = 1'b1;
    idle();
    check("t3_valid_drop", valid_m, 1'b0);
    check("t3_overrun_sticky", ovr_m, 1'b1);
    idle();
    check("t3_overrun_sticky2", ovr_m, 1'b1);

    // Load on same-cycle transfer
    do_reset();
    check("t4_overrun_cleared", ovr_m, 1'b0);
    dout_ready = 1'b0;
    send_word(8'h33, 1'b0, 1'b0);
    check("t4_hold_33", dout_m, 8'h33);
    send_word(8'h44, 1'b0, 1'b1);
    check("t4_dout_44", dout_m, 8'h44);
    check("t4_valid_stays", valid_m, 1'b1);
    check("t4_no_overrun", ovr_m, 1'b0);
    idle();
    check("t4_drained", valid_m, 1'b0);

    // Mid-frame start
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t5_no_err_before", ferr_m, 1'b0);
    send_bit(1'b1, 1'b1);
    check("t5_frame_err_pulse", ferr_m, 1'b1);
    check("t5_busy_restart", busy_m, 1'b1);
    send_bit(1'b1, 1'b0);
    check("t5_frame_err_once", ferr_m, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
    if (par_en) send_bit(1'b0, 1'b0);
    check("t5_dout", dout_m, 8'hFF);
    check("t5_valid", valid_m, 1'b1);
    check("t5_lsb_dout", dout_l, 8'hFF);
    idle();

    // Gaps inside a frame hold state
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    idle();
    idle();
    idle();
    check("gap_busy", busy_m, 1'b1);
    check("gap_no_word", valid_m, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    if (par_en) send_bit(1'b0, 1'b0);
    check("gap_dout", dout_m, 8'h5A);
    check("gap_lsb_dout", dout_l, 8'h5A);
    idle();

`ifdef SERIAL_PARITY_CHECK_EN
    // Parity: 8'h07 has odd data weight
    send_word(8'h07, 1'b1, 1'b0);
    check("par_ok_dout", dout_m, 8'h07);
    check("par_ok", perr_m, 1'b0);
    idle();
    send_word(8'h07, 1'b0, 1'b0);
    check("par_bad", perr_m, 1'b1);
    idle();
`else
    check("par_tied_low", perr_m, 1'b0);
`endif

    // Reset mid-frame with a held word
    dout_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    check("rstmid_held", valid_m, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("rstmid_busy_before", busy_m, 1'b1);
    do_reset();
    check("rstmid_busy", busy_m, 1'b0);
    check("rstmid_valid", valid_m, 1'b0);
    check("rstmid_frame_err", ferr_m, 1'b0);
    check("rstmid_dout", dout_m, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Remaining seven bits of 8'hA5 after its start bit, plus even parity when built in.
  task automatic send_word_tail();
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    if (par_en) send_bit(^w, 1'b0);
  endtask

endmodule
